// File: rtl/sram_arbiter.sv
// sram_arbiter: per-cycle arbiter/sequencer for the shared 256Kx16 async frame SRAM (VGA vs GPU).
// Define SRAM_ARB_STARVE_GUARD_EN to let a waiting GPU win after STARVE_LIMIT VGA grants.
module sram_arbiter #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_VGA_REQ,
    input  logic [ADDR_W-1:0] I_VGA_ADDR,
    output logic [DATA_W-1:0] O_VGA_DATA,
    output logic              O_VGA_VALID,
    input  logic              I_GPU_REQ,
    input  logic              I_GPU_WE,
    input  logic [ADDR_W-1:0] I_GPU_ADDR,
    input  logic [DATA_W-1:0] I_GPU_DATA,
    output logic [DATA_W-1:0] O_GPU_DATA,
    output logic              O_GPU_ACK,
    inout  wire  [DATA_W-1:0] IO_SRAM_DQ,
    output logic [ADDR_W-1:0] O_SRAM_ADDR,
    output logic              O_SRAM_WE_N,
    output logic              O_SRAM_OE_N,
    output logic              O_SRAM_CE_N,
    output logic              O_SRAM_UB_N,
    output logic              O_SRAM_LB_N
);

    typedef enum logic [2:0] {StIdle, StVgaRd, StGpuRd, StGpuWr, StWrRec} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   dq_out_q;
    logic                dq_oe_q;
    logic                we_n_q, oe_n_q, ce_n_q;
    logic [DATA_W-1:0]   vga_data_q, gpu_data_q;
    logic                vga_valid_q, gpu_ack_q;

    logic decide, gpu_masked, vga_elig, gpu_elig, gpu_force;
    logic grant_vga, grant_gpu;

    always_comb begin
        decide     = (state_q != StGpuWr);
        // Hold off a request that was just served until the requester has seen its ACK.
        gpu_masked = (state_q == StGpuRd) || (state_q == StWrRec) || gpu_ack_q;
        vga_elig   = I_VGA_REQ;
        gpu_elig   = I_GPU_REQ && !gpu_masked;
        grant_gpu  = decide && gpu_elig && (!vga_elig || gpu_force);
        grant_vga  = decide && vga_elig && !grant_gpu;

        state_d = StIdle;
        if (!decide) begin
            state_d = StWrRec;
        end else if (grant_vga) begin
            state_d = StVgaRd;
        end else if (grant_gpu) begin
            state_d = I_GPU_WE ? StGpuWr : StGpuRd;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            vga_data_q  <= '0;
            gpu_data_q  <= '0;
            vga_valid_q <= 1'b0;
            gpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ce_n_q      <= 1'b0;
            oe_n_q      <= !((state_d == StVgaRd) || (state_d == StGpuRd));
            we_n_q      <= (state_d != StGpuWr);
            // Keep driving through WR_REC so data is stable when WE_N rises.
            dq_oe_q     <= (state_d == StGpuWr) || (state_d == StWrRec);
            vga_valid_q <= (state_q == StVgaRd);
            gpu_ack_q   <= (state_q == StGpuRd) || (state_q == StWrRec);
            if (state_q == StVgaRd) begin
                vga_data_q <= IO_SRAM_DQ;
            end
            if (state_q == StGpuRd) begin
                gpu_data_q <= IO_SRAM_DQ;
            end
            if (grant_vga) begin
                addr_q <= I_VGA_ADDR;
            end else if (grant_gpu) begin
                addr_q <= I_GPU_ADDR;
                if (I_GPU_WE) begin
                    dq_out_q <= I_GPU_DATA;
                end
            end
        end
    end

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign gpu_force = (starve_cnt_q == StarveLimit);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!gpu_elig || grant_gpu) begin
            starve_cnt_d = 8'd0;
        end else if (grant_vga) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign gpu_force           = 1'b0;
`endif

    assign IO_SRAM_DQ  = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign O_SRAM_ADDR = addr_q;
    assign O_SRAM_WE_N = we_n_q;
    assign O_SRAM_OE_N = oe_n_q;
    assign O_SRAM_CE_N = ce_n_q;
    assign O_SRAM_UB_N = 1'b0;
    assign O_SRAM_LB_N = 1'b0;
    assign O_VGA_DATA  = vga_data_q;
    assign O_VGA_VALID = vga_valid_q;
    assign O_GPU_DATA  = gpu_data_q;
    assign O_GPU_ACK   = gpu_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus hand sequences for reset, starvation and dropped reads.
module tb_sram_arbiter;

    logic        clk, rst_n;
    logic        vga_req, gpu_req, gpu_we;
    logic [17:0] vga_addr, gpu_addr;
    logic [15:0] gpu_wdata;
    logic [15:0] vga_data, gpu_data;
    logic        vga_valid, gpu_ack;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .STARVE_LIMIT(8)) dut (
        .I_CLK       (clk),
        .I_RST_N     (rst_n),
        .I_VGA_REQ   (vga_req),
        .I_VGA_ADDR  (vga_addr),
        .O_VGA_DATA  (vga_data),
        .O_VGA_VALID (vga_valid),
        .I_GPU_REQ   (gpu_req),
        .I_GPU_WE    (gpu_we),
        .I_GPU_ADDR  (gpu_addr),
        .I_GPU_DATA  (gpu_wdata),
        .O_GPU_DATA  (gpu_data),
        .O_GPU_ACK   (gpu_ack),
        .IO_SRAM_DQ  (sram_dq),
        .O_SRAM_ADDR (sram_addr),
        .O_SRAM_WE_N (sram_we_n),
        .O_SRAM_OE_N (sram_oe_n),
        .O_SRAM_CE_N (sram_ce_n),
        .O_SRAM_UB_N (sram_ub_n),
        .O_SRAM_LB_N (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one written word remembered, every other word reads back as addr[15:0].
    logic        wr_valid;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] model_rd;

    assign model_rd = (wr_valid && sram_addr == wr_addr) ? wr_data : sram_addr[15:0];
    assign sram_dq  = (!sram_oe_n && !sram_ce_n && sram_we_n) ? model_rd : 16'hzzzz;

    initial wr_valid = 1'b0;
    always @(posedge clk) begin
        if (rst_n && !sram_we_n && !sram_ce_n) begin
            wr_valid <= 1'b1;
            wr_addr  <= sram_addr;
            wr_data  <= sram_dq;
        end
    end

    typedef struct packed {
        logic        vreq;
        logic [17:0] vaddr;
        logic        greq;
        logic        gwe;
        logic [17:0] gaddr;
        logic [15:0] gwdata;
        logic        e_vvalid;
        logic [15:0] e_vdata;
        logic        e_gack;
        logic [15:0] e_gdata;
        logic [17:0] e_addr;
        logic        e_we_n;
        logic        e_oe_n;
        logic        chk_dq;
        logic [15:0] e_dq;
    } vec_t;

    function automatic vec_t mk(input logic vreq, input logic [17:0] vaddr, input logic greq,
                                input logic gwe, input logic [17:0] gaddr,
                                input logic [15:0] gwdata, input logic e_vvalid,
                                input logic [15:0] e_vdata, input logic e_gack,
                                input logic [15:0] e_gdata, input logic [17:0] e_addr,
                                input logic e_we_n, input logic e_oe_n, input logic chk_dq,
                                input logic [15:0] e_dq);
        vec_t v;
        v = {vreq, vaddr, greq, gwe, gaddr, gwdata, e_vvalid, e_vdata, e_gack, e_gdata,
             e_addr, e_we_n, e_oe_n, chk_dq, e_dq};
        return v;
    endfunction

    localparam int NumVec = 18;
    vec_t vecs [NumVec];

    int n_tests, n_fail;
    int n_vga;
    logic gpu_granted, got_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //           vreq vaddr   greq we gaddr    gwdata   vv vdata    ga gdata    addr     wen oen cd dq
        vecs[0]  = mk(1, 18'h10,    0, 0, 18'h0,     16'h0,    0, 16'h0000, 0, 16'h0000, 18'h10,    1, 0, 0, 16'h0);
        vecs[1]  = mk(1, 18'h11,    0, 0, 18'h0,     16'h0,    1, 16'h0010, 0, 16'h0000, 18'h11,    1, 0, 0, 16'h0);
        vecs[2]  = mk(1, 18'h12,    0, 0, 18'h0,     16'h0,    1, 16'h0011, 0, 16'h0000, 18'h12,    1, 0, 0, 16'h0);
        vecs[3]  = mk(1, 18'h13,    0, 0, 18'h0,     16'h0,    1, 16'h0012, 0, 16'h0000, 18'h13,    1, 0, 0, 16'h0);
        vecs[4]  = mk(0, 18'h0,     0, 0, 18'h0,     16'h0,    1, 16'h0013, 0, 16'h0000, 18'h13,    1, 1, 0, 16'h0);
        vecs[5]  = mk(0, 18'h0,     0, 0, 18'h0,     16'h0,    0, 16'h0013, 0, 16'h0000, 18'h13,    1, 1, 0, 16'h0);
        vecs[6]  = mk(0, 18'h0,     1, 1, 18'h3FFFF, 16'hBEEF, 0, 16'h0013, 0, 16'h0000, 18'h3FFFF, 0, 1, 1, 16'hBEEF);
        vecs[7]  = mk(1, 18'h30,    1, 1, 18'h3FFFF, 16'hBEEF, 0, 16'h0013, 0, 16'h0000, 18'h3FFFF, 1, 1, 1, 16'hBEEF);
        vecs[8]  = mk(1, 18'h20,    1, 1, 18'h3FFFF, 16'hBEEF, 0, 16'h0013, 1, 16'h0000, 18'h20,    1, 0, 1, 16'h0020);
        vecs[9]  = mk(0, 18'h0,     1, 0, 18'h3FFFF, 16'h0,    1, 16'h0020, 0, 16'h0000, 18'h20,    1, 1, 0, 16'h0);
        vecs[10] = mk(0, 18'h0,     1, 0, 18'h3FFFF, 16'h0,    0, 16'h0020, 0, 16'h0000, 18'h3FFFF, 1, 0, 1, 16'hBEEF);
        vecs[11] = mk(0, 18'h0,     1, 0, 18'h3FFFF, 16'h0,    0, 16'h0020, 1, 16'hBEEF, 18'h3FFFF, 1, 1, 0, 16'h0);
        vecs[12] = mk(0, 18'h0,     0, 0, 18'h0,     16'h0,    0, 16'h0020, 0, 16'hBEEF, 18'h3FFFF, 1, 1, 0, 16'h0);
        vecs[13] = mk(1, 18'h40,    1, 0, 18'h50,    16'h0,    0, 16'h0020, 0, 16'hBEEF, 18'h40,    1, 0, 0, 16'h0);
        vecs[14] = mk(0, 18'h0,     1, 0, 18'h50,    16'h0,    1, 16'h0040, 0, 16'hBEEF, 18'h50,    1, 0, 0, 16'h0);
        vecs[15] = mk(0, 18'h0,     1, 0, 18'h50,    16'h0,    0, 16'h0040, 1, 16'h0050, 18'h50,    1, 1, 0, 16'h0);
        vecs[16] = mk(0, 18'h0,     1, 0, 18'h50,    16'h0,    0, 16'h0040, 0, 16'h0050, 18'h50,    1, 1, 0, 16'h0);
        vecs[17] = mk(0, 18'h0,     0, 0, 18'h0,     16'h0,    0, 16'h0040, 0, 16'h0050, 18'h50,    1, 1, 0, 16'h0);

        rst_n = 1'b0; vga_req = 1'b0; vga_addr = '0;
        gpu_req = 1'b0; gpu_we = 1'b0; gpu_addr = '0; gpu_wdata = '0;
        #12;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_ub_lb", {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
        check("rst_flags", {30'd0, vga_valid, gpu_ack}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ce_after_rst", 32'(sram_ce_n), 32'd0);

        for (int i = 0; i < NumVec; i++) begin
            vga_req   = vecs[i].vreq;
            vga_addr  = vecs[i].vaddr;
            gpu_req   = vecs[i].greq;
            gpu_we    = vecs[i].gwe;
            gpu_addr  = vecs[i].gaddr;
            gpu_wdata = vecs[i].gwdata;
            @(negedge clk);
            check($sformatf("v%0d_vga_valid", i), 32'(vga_valid), 32'(vecs[i].e_vvalid));
            check($sformatf("v%0d_vga_data", i), 32'(vga_data), 32'(vecs[i].e_vdata));
            check($sformatf("v%0d_gpu_ack", i), 32'(gpu_ack), 32'(vecs[i].e_gack));
            check($sformatf("v%0d_gpu_data", i), 32'(gpu_data), 32'(vecs[i].e_gdata));
            check($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_we_n", i), 32'(sram_we_n), 32'(vecs[i].e_we_n));
            check($sformatf("v%0d_oe_n", i), 32'(sram_oe_n), 32'(vecs[i].e_oe_n));
            if (vecs[i].chk_dq) begin
                check($sformatf("v%0d_dq", i), 32'(sram_dq), 32'(vecs[i].e_dq));
            end
        end

        // Starvation: VGA requests every cycle while a GPU read waits.
        vga_req = 1'b1; vga_addr = 18'h100;
        gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 18'h60;
        n_vga = 0;
        gpu_granted = 1'b0;
        for (int c = 0; c < 100 && !gpu_granted; c++) begin
            @(negedge clk);
            if (!sram_oe_n && sram_addr == 18'h60) begin
                gpu_granted = 1'b1;
            end else if (!sram_oe_n) begin
                n_vga++;
            end
            vga_addr = vga_addr + 18'd1;
        end
`ifdef SRAM_ARB_STARVE_GUARD_EN
        check("starve_gpu_granted", 32'(gpu_granted), 32'd1);
        check("starve_vga_grants", 32'(n_vga), 32'd8);
`else
        check("starve_gpu_granted", 32'(gpu_granted), 32'd0);
        check("starve_vga_grants", 32'(n_vga), 32'd100);
`endif
        vga_req = 1'b0;
        got_ack = 1'b0;
        for (int c = 0; c < 10 && !got_ack; c++) begin
            @(negedge clk);
            if (gpu_ack) begin
                got_ack = 1'b1;
            end
        end
        check("starve_ack", 32'(got_ack), 32'd1);
        check("starve_gpu_data", 32'(gpu_data), 32'h0060);
        gpu_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a write.
        gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 18'h00123; gpu_wdata = 16'h5A5A;
        @(negedge clk);
        check("mw_we_low", 32'(sram_we_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mw_rst_we_n", 32'(sram_we_n), 32'd1);
        check("mw_rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("mw_rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("mw_rst_addr", 32'(sram_addr), 32'd0);
        check("mw_rst_dq_released", 32'(sram_dq !== 16'h5A5A), 32'd1);
        check("mw_rst_vga_data", 32'(vga_data), 32'd0);
        check("mw_rst_gpu_data", 32'(gpu_data), 32'd0);
        check("mw_rst_flags", {30'd0, vga_valid, gpu_ack}, 32'd0);
        gpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Clocked arbiter and sequencer for the single shared 256K×16 asynchronous frame SRAM. It grants each cycle's SRAM access to either the VGA scan-out reader or the GPU read/write port. It drives registered SRAM control, address and data pins, and returns read data to each requester with a fixed latency. It sits between the VGA timing/prefetch logic, the GPU pipeline and the board SRAM pins.

## Interface
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, SRAM data width
- STARVE_LIMIT, 8, consecutive VGA grants tolerated while GPU waits (only with guard enabled; legal 1–255)
- I_CLK  in  1  system clock; all logic on rising edge
- I_RST_N  in  1  reset, asynchronous, active-low
- I_VGA_REQ  in  1  single-cycle read request; not queued
- I_VGA_ADDR  in  ADDR_W  VGA read address, sampled with I_VGA_REQ
- O_VGA_DATA  out  DATA_W  captured read data, held until next VGA read
- O_VGA_VALID  out  1  one-cycle pulse: O_VGA_DATA updated
- I_GPU_REQ  in  1  request; held with ADDR/WE/DATA stable until O_GPU_ACK
- I_GPU_WE  in  1  1 = write, 0 = read
- I_GPU_ADDR  in  ADDR_W  GPU address
- I_GPU_DATA  in  DATA_W  GPU write data
- O_GPU_DATA  out  DATA_W  read data, valid with O_GPU_ACK, held afterwards
- O_GPU_ACK  out  1  one-cycle completion pulse
- IO_SRAM_DQ  inout  DATA_W  SRAM data bus
- O_SRAM_ADDR  out  ADDR_W  registered address
- O_SRAM_WE_N, O_SRAM_OE_N, O_SRAM_CE_N, O_SRAM_UB_N, O_SRAM_LB_N  out  1 each  registered active-low controls

## Operation
- States: IDLE, VGA_RD, GPU_RD, GPU_WR, WR_REC.
- Grant decision is made at each edge leaving IDLE, VGA_RD, GPU_RD or WR_REC. GPU_WR always goes to WR_REC.
- Eligibility:
  - VGA is eligible if I_VGA_REQ = 1.
  - GPU is eligible if I_GPU_REQ = 1 and the GPU is not masked.
  - The GPU is masked at the edge ending GPU_RD/WR_REC and at the edge ending the following O_GPU_ACK cycle, so an already-served request is never re-granted.
- Priority: VGA over GPU, except as described under Configuration. The loser is not served.
- A VGA request not granted (lost to GPU, or sampled at the edge ending GPU_WR) is dropped: no O_VGA_VALID for it. Upstream re-requests.
- Pins per state:
  - IDLE: CE_N=0, OE_N=1, WE_N=1, DQ hi-Z, address holds.
  - VGA_RD/GPU_RD: address = granted address, OE_N=0, WE_N=1, DQ hi-Z.
  - GPU_WR: address = GPU address, OE_N=1, WE_N=0, DQ = I_GPU_DATA.
  - WR_REC: WE_N=1, address and DQ held, OE_N=1.
- UB_N=LB_N=0 always (full-word access).
- Read capture: IO_SRAM_DQ is sampled at the edge ending VGA_RD/GPU_RD into O_VGA_DATA/O_GPU_DATA.
- Reset values: state IDLE; O_SRAM_ADDR=0; WE_N=1, OE_N=1, CE_N=1, UB_N=LB_N=0; DQ hi-Z; O_VGA_DATA=0, O_GPU_DATA=0; O_VGA_VALID=0, O_GPU_ACK=0; starve counter 0.
- Reset asserted mid-write: WE_N deasserts immediately and the target word content is undefined. Requesters must reissue after reset.

## Timing
- VGA read: request sampled at edge N; VGA_RD for cycle N..N+1; data captured at edge N+1; O_VGA_VALID high cycle N+1..N+2. Latency 2 edges.
- Back-to-back VGA reads sustain 1 per cycle.
- GPU read: granted at edge N → GPU_RD → O_GPU_ACK + data in cycle after edge N+1. Minimum GPU-read spacing is 3 cycles.
- GPU write: granted at edge N → GPU_WR (1 cycle) → WR_REC (1 cycle). O_GPU_ACK is high in the cycle after WR_REC ends. The write occupies the SRAM for 2 cycles.
- DQ is released at the edge leaving WR_REC, so any read state after a write has no bus contention.

## Configuration
- SRAM_ARB_STARVE_GUARD_EN defined:
  - An 8-bit counter increments on each VGA grant made while the GPU is eligible.
  - It clears on any GPU grant, or when the GPU is not eligible.
  - When the counter equals STARVE_LIMIT and the GPU is eligible, the GPU wins the next decision over VGA, and the counter clears.
- Macro undefined: strict VGA priority; the counter is absent; the GPU can starve indefinitely.

## Test plan
- Reset: assert I_RST_N=0 mid-GPU_WR → WE_N=1, OE_N=1, CE_N=1 immediately, DQ hi-Z, all outputs at reset values.
- VGA stream: VGA_REQ high 4 cycles, addresses 0x00010–0x00013, SRAM model returns addr[15:0] → four consecutive O_VGA_VALID pulses with data 0x0010–0x0013, first pulse 2 edges after first request.
- GPU write then read: write 0xBEEF to 0x3FFFF, then read it → WE_N low exactly 1 cycle with DQ=0xBEEF; each op gets one ACK; read returns 0xBEEF; no DQ contention on the WR_REC→read transition.
- Collision: VGA and GPU read requested at the same edge → VGA served first; GPU ACK follows; the GPU request is never granted twice.
- Dropped VGA: VGA_REQ at the edge ending GPU_WR → no O_VGA_VALID for that address.
- Starvation (SRAM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=8): VGA_REQ held high continuously plus GPU read pending → GPU granted after exactly 8 VGA grants. Without the macro, no GPU grant within 100 cycles.
